lcd_win_stats: RTL and testbench



---
 rtl/lcd_pkg.sv | 35 +++
 rtl/win_acc.sv | 39 +++
 rtl/lcd_win_stats.sv | 188 ++++++++++++++++++
 tb/tb_lcd_win_stats.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD display controller and its window consumers.
package lcd_pkg;

   localparam int unsigned PIX_W_DEF = 8;
   localparam int unsigned WIN_N     = 9;
   localparam int unsigned WIN_CTR   = 4;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned CNT_W     = 4;

   // Sum of WIN_N pixels needs four extra bits over the pixel width.
   function automatic int unsigned sum_w(input int unsigned pix_w);
      return pix_w + 4;
   endfunction

   localparam int unsigned SUM_W = sum_w(PIX_W_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } win_state_t;

   // Command codes accepted by the display controller.
   typedef enum logic [2:0] {
      CMD_NOP        = 3'd0,
      CMD_RESET      = 3'd1,
      CMD_LOAD_IMG   = 3'd2,
      CMD_SHIFT_UP   = 3'd3,
      CMD_SHIFT_DOWN = 3'd4,
      CMD_SHIFT_LEFT = 3'd5,
      CMD_SHIFT_RGT  = 3'd6,
      CMD_READ_WIN   = 3'd7
   } lcd_cmd_t;

endpackage

// File: rtl/win_acc.sv
// Next-value datapath for the window statistics accumulator; seed restarts from the pixel.
module win_acc
   import lcd_pkg::*;
#(
   parameter int unsigned          PIX_W  = 8,
   parameter logic [PIX_W-1:0]     THRESH = PIX_W'(128)
) (
   input  logic                   seed,
   input  logic [PIX_W-1:0]       pix,
   input  logic [PIX_W+4-1:0]     sum,
   input  logic [PIX_W-1:0]       min_v,
   input  logic [PIX_W-1:0]       max_v,
   input  logic [CNT_W-1:0]       cnt,
   output logic [PIX_W+4-1:0]     sum_nxt_c,
   output logic [PIX_W-1:0]       min_nxt_c,
   output logic [PIX_W-1:0]       max_nxt_c,
   output logic [CNT_W-1:0]       cnt_nxt_c
);

   localparam int unsigned RSUM_W = sum_w(PIX_W);

   logic above_c;

   always_comb begin
      above_c = (pix > THRESH);
      if (seed) begin
         sum_nxt_c = RSUM_W'(pix);
         min_nxt_c = pix;
         max_nxt_c = pix;
         cnt_nxt_c = CNT_W'(above_c);
      end else begin
         sum_nxt_c = sum + RSUM_W'(pix);
         min_nxt_c = (pix < min_v) ? pix : min_v;
         max_nxt_c = (pix > max_v) ? pix : max_v;
         cnt_nxt_c = cnt + CNT_W'(above_c);
      end
   end

endmodule

// File: rtl/lcd_win_stats.sv
// Captures 3x3 window bursts from the LCD controller and publishes sum/min/max/centre/count
// through a valid/ready result register; the next burst accumulates while a result is pending.
module lcd_win_stats
   import lcd_pkg::*;
#(
   parameter int unsigned      PIX_W  = 8,
   parameter logic [PIX_W-1:0] THRESH = PIX_W'(128)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PIX_W-1:0]     pix_in,
   input  logic                 pix_valid,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [PIX_W+4-1:0]   res_sum,
   output logic [PIX_W-1:0]     res_min,
   output logic [PIX_W-1:0]     res_max,
   output logic [PIX_W-1:0]     res_ctr,
   output logic [CNT_W-1:0]     res_cnt,
   output logic                 short_err,
   output logic                 overrun
);

   localparam int unsigned       RSUM_W   = sum_w(PIX_W);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIN_N - 1);
   localparam logic [IDX_W-1:0]  IDX_CTR  = IDX_W'(WIN_CTR);

   win_state_t          state, state_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;

   logic [RSUM_W-1:0]   acc_sum, acc_sum_nxt;
   logic [PIX_W-1:0]    acc_min, acc_min_nxt;
   logic [PIX_W-1:0]    acc_max, acc_max_nxt;
   logic [PIX_W-1:0]    acc_ctr, acc_ctr_nxt;
   logic [CNT_W-1:0]    acc_cnt, acc_cnt_nxt;

   logic                res_valid_nxt;
   logic [RSUM_W-1:0]   res_sum_nxt;
   logic [PIX_W-1:0]    res_min_nxt, res_max_nxt, res_ctr_nxt;
   logic [CNT_W-1:0]    res_cnt_nxt;
   logic                short_err_nxt, overrun_nxt;

   logic                seed_c;
   logic [RSUM_W-1:0]   dp_sum_c;
   logic [PIX_W-1:0]    dp_min_c, dp_max_c;
   logic [CNT_W-1:0]    dp_cnt_c;

   win_acc #(
      .PIX_W  (PIX_W),
      .THRESH (THRESH)
   ) u_win_acc (
      .seed      (seed_c),
      .pix       (pix_in),
      .sum       (acc_sum),
      .min_v     (acc_min),
      .max_v     (acc_max),
      .cnt       (acc_cnt),
      .sum_nxt_c (dp_sum_c),
      .min_nxt_c (dp_min_c),
      .max_nxt_c (dp_max_c),
      .cnt_nxt_c (dp_cnt_c)
   );

   // State, index, accumulator and result register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         acc_sum   <= '0;
         acc_min   <= '0;
         acc_max   <= '0;
         acc_ctr   <= '0;
         acc_cnt   <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_min   <= '0;
         res_max   <= '0;
         res_ctr   <= '0;
         res_cnt   <= '0;
         short_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         acc_sum   <= acc_sum_nxt;
         acc_min   <= acc_min_nxt;
         acc_max   <= acc_max_nxt;
         acc_ctr   <= acc_ctr_nxt;
         acc_cnt   <= acc_cnt_nxt;
         res_valid <= res_valid_nxt;
         res_sum   <= res_sum_nxt;
         res_min   <= res_min_nxt;
         res_max   <= res_max_nxt;
         res_ctr   <= res_ctr_nxt;
         res_cnt   <= res_cnt_nxt;
         short_err <= short_err_nxt;
         overrun   <= overrun_nxt;
      end
   end

   // Next-state and next-value logic
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      seed_c        = 1'b0;
      acc_sum_nxt   = acc_sum;
      acc_min_nxt   = acc_min;
      acc_max_nxt   = acc_max;
      acc_ctr_nxt   = acc_ctr;
      acc_cnt_nxt   = acc_cnt;
      res_valid_nxt = res_valid && !res_ready;
      res_sum_nxt   = res_sum;
      res_min_nxt   = res_min;
      res_max_nxt   = res_max;
      res_ctr_nxt   = res_ctr;
      res_cnt_nxt   = res_cnt;
      short_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            if (pix_valid) begin
               seed_c      = 1'b1;
               acc_sum_nxt = dp_sum_c;
               acc_min_nxt = dp_min_c;
               acc_max_nxt = dp_max_c;
               acc_cnt_nxt = dp_cnt_c;
               idx_nxt     = IDX_W'(1);
               state_nxt   = ACC;
            end
         end

         ACC: begin
            if (pix_valid) begin
               acc_sum_nxt = dp_sum_c;
               acc_min_nxt = dp_min_c;
               acc_max_nxt = dp_max_c;
               acc_cnt_nxt = dp_cnt_c;
               if (idx == IDX_CTR) begin
                  acc_ctr_nxt = pix_in;
               end
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end else begin
               short_err_nxt = 1'b1;
               idx_nxt       = '0;
               state_nxt     = IDLE;
            end
         end

         DONE: begin
            // A consume in this cycle frees the register for the new result.
            if (!res_valid || res_ready) begin
               res_valid_nxt = 1'b1;
               res_sum_nxt   = acc_sum;
               res_min_nxt   = acc_min;
               res_max_nxt   = acc_max;
               res_ctr_nxt   = acc_ctr;
               res_cnt_nxt   = acc_cnt;
            end else begin
               overrun_nxt = 1'b1;
            end
            if (pix_valid) begin
               seed_c      = 1'b1;
               acc_sum_nxt = dp_sum_c;
               acc_min_nxt = dp_min_c;
               acc_max_nxt = dp_max_c;
               acc_cnt_nxt = dp_cnt_c;
               idx_nxt     = IDX_W'(1);
               state_nxt   = ACC;
            end else begin
               idx_nxt   = '0;
               state_nxt = IDLE;
            end
         end

         default: begin
            idx_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_win_stats.sv
// Directed bench for lcd_win_stats with a result scoreboard checked on each handshake.
module tb_lcd_win_stats;

   typedef struct packed {
      logic [11:0] sum;
      logic [7:0]  mn;
      logic [7:0]  mx;
      logic [7:0]  ctr;
      logic [3:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        res_valid;
   logic        res_ready;
   logic [11:0] res_sum;
   logic [7:0]  res_min;
   logic [7:0]  res_max;
   logic [7:0]  res_ctr;
   logic [3:0]  res_cnt;
   logic        short_err;
   logic        overrun;

   int checks    = 0;
   int errors    = 0;
   int short_cnt = 0;
   int ovr_cnt   = 0;
   int consumed  = 0;
   int s0;

   exp_t       sb[$];
   logic [7:0] pb[9];

   lcd_win_stats dut (
      .clk       (clk),
      .reset     (reset),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_min   (res_min),
      .res_max   (res_max),
      .res_ctr   (res_ctr),
      .res_cnt   (res_cnt),
      .short_err (short_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] p[9]);
      exp_t e;
      e.sum = '0;
      e.mn  = 8'd255;
      e.mx  = 8'd0;
      e.cnt = '0;
      for (int i = 0; i < 9; i++) begin
         e.sum = e.sum + 12'(p[i]);
         if (p[i] < e.mn) e.mn = p[i];
         if (p[i] > e.mx) e.mx = p[i];
         if (p[i] > 8'd128) e.cnt = e.cnt + 4'd1;
      end
      e.ctr = p[4];
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill(input int base, input int step);
      for (int i = 0; i < 9; i++) pb[i] = 8'(base + i * step);
   endtask

   // Drives n pixels, one per edge; returns 1 time unit after the last pixel edge.
   task automatic send(input int n, input bit push);
      if (push) sb.push_back(model(pb));
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         pix_in    = pb[i];
         tick(1);
      end
      pix_valid = 1'b0;
      pix_in    = '0;
   endtask

   // Scoreboard: compare every consumed result against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (short_err) short_cnt++;
         if (overrun) ovr_cnt++;
         if (res_valid && res_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_result: observed sum %0d expected no result", res_sum);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               consumed++;
               chk("res_sum", 32'(res_sum), 32'(e.sum));
               chk("res_min", 32'(res_min), 32'(e.mn));
               chk("res_max", 32'(res_max), 32'(e.mx));
               chk("res_ctr", 32'(res_ctr), 32'(e.ctr));
               chk("res_cnt", 32'(res_cnt), 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_in    = '0;
      res_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(res_valid), 0);
      chk("rst_sum", 32'(res_sum), 0);
      chk("rst_min", 32'(res_min), 0);
      chk("rst_max", 32'(res_max), 0);
      chk("rst_ctr", 32'(res_ctr), 0);
      chk("rst_cnt", 32'(res_cnt), 0);
      chk("rst_short", 32'(short_err), 0);
      chk("rst_ovr", 32'(overrun), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick(1);

      // Ramp burst: latency and single-cycle valid with ready held high
      res_ready = 1'b1;
      fill(10, 10);
      send(9, 1'b1);
      @(negedge clk);
      chk("lat_done_cycle", 32'(res_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_after_e9", 32'(res_valid), 1);
      @(posedge clk);
      @(negedge clk);
      chk("valid_one_cycle", 32'(res_valid), 0);
      @(posedge clk);
      #1;

      // Saturated burst
      fill(255, 0);
      send(9, 1'b1);
      tick(3);

      // Short burst then a full burst of 1s
      s0 = short_cnt;
      fill(40, 3);
      send(5, 1'b0);
      tick(1);
      @(negedge clk);
      chk("short_pulse", 32'(short_err), 1);
      chk("short_no_valid", 32'(res_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("short_one_cycle", 32'(short_err), 0);
      @(posedge clk);
      #1;
      fill(1, 0);
      send(9, 1'b1);
      tick(3);
      chk("short_count", 32'(short_cnt), 32'(s0 + 1));

      // Stalled consumer: second burst overruns
      res_ready = 1'b0;
      fill(1, 0);
      send(9, 1'b1);
      tick(1);
      fill(2, 0);
      send(9, 1'b0);
      @(negedge clk);
      chk("ovr_not_yet", 32'(overrun), 0);
      @(posedge clk);
      @(negedge clk);
      chk("ovr_pulse", 32'(overrun), 1);
      chk("ovr_hold_valid", 32'(res_valid), 1);
      chk("ovr_hold_sum", 32'(res_sum), 9);
      @(posedge clk);
      #1;
      chk("ovr_one_cycle", 32'(overrun), 0);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("drain_valid_low", 32'(res_valid), 0);
      @(posedge clk);
      #1;

      // Consume and refill in the same DONE cycle
      res_ready = 1'b0;
      fill(1, 0);
      send(9, 1'b1);
      tick(1);
      fill(2, 0);
      send(9, 1'b1);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("refill_valid", 32'(res_valid), 1);
      chk("refill_sum", 32'(res_sum), 18);
      chk("refill_no_ovr", 32'(overrun), 0);
      @(posedge clk);
      @(negedge clk);
      chk("refill_drained", 32'(res_valid), 0);
      @(posedge clk);
      #1;
      chk("ovr_count", 32'(ovr_cnt), 1);

      // Random burst straddling the threshold
      for (int i = 0; i < 9; i++) pb[i] = 8'($urandom_range(0, 255));
      send(9, 1'b1);
      tick(3);

      // Reset mid-burst with a result pending
      res_ready = 1'b0;
      fill(5, 0);
      send(9, 1'b0);
      tick(2);
      chk("pre_reset_valid", 32'(res_valid), 1);
      s0 = short_cnt;
      fill(7, 0);
      send(5, 1'b0);
      reset = 1'b1;
      #1;
      chk("async_valid", 32'(res_valid), 0);
      chk("async_sum", 32'(res_sum), 0);
      chk("async_min", 32'(res_min), 0);
      chk("async_max", 32'(res_max), 0);
      chk("async_ctr", 32'(res_ctr), 0);
      tick(2);
      reset = 1'b0;
      res_ready = 1'b1;
      tick(1);
      fill(3, 0);
      send(9, 1'b1);
      tick(3);
      chk("reset_no_short", 32'(short_cnt), 32'(s0));

      chk("sb_empty", 32'(sb.size()), 0);
      chk("consumed", 32'(consumed), 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
